recognition_frame_ctrl: RTL

//  Per-frame sequencer for the digit recognition datapath.
//  - Latches the bounding box at frame start and checks its geometry.
//  - Clears the recognizer, enables it for one active frame, then samples its verdict.
//  - Publishes a digit only after STABLE_FRAMES consecutive agreeing frames.

---
 rtl/recognition_frame_ctrl_if.sv | 26 ++
 rtl/recognition_frame_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/recognition_frame_ctrl_if.sv
// Bus bundle between the frame sequencer and its neighbours: the box detector,
// the VGA timing source and the digit recognizer.
interface recognition_frame_ctrl_if;
  logic        iFrameStart;
  logic        iFrameEnd;
  logic [19:0] iEdge_Row;
  logic [19:0] iEdge_Col;
  logic [3:0]  iDigital;
  logic [19:0] oEdge_Row;
  logic [19:0] oEdge_Col;
  logic        oRecEn;
  logic        oRecRst_n;
  logic [3:0]  oDigital;
  logic        oValid;
  logic        oBusy;

  modport slave (
    input  iFrameStart, iFrameEnd, iEdge_Row, iEdge_Col, iDigital,
    output oEdge_Row, oEdge_Col, oRecEn, oRecRst_n, oDigital, oValid, oBusy
  );

  modport master (
    output iFrameStart, iFrameEnd, iEdge_Row, iEdge_Col, iDigital,
    input  oEdge_Row, oEdge_Col, oRecEn, oRecRst_n, oDigital, oValid, oBusy
  );
endinterface

// File: rtl/recognition_frame_ctrl.sv
// Per-frame sequencer for the digit recognition datapath: latches and checks the
// bounding box, clears and enables the recognizer for one frame, samples its
// verdict and publishes a digit once it has agreed for STABLE_FRAMES frames.
module recognition_frame_ctrl #(
  parameter int H_ACT         = 640,
  parameter int V_ACT         = 480,
  parameter int MIN_BOX       = 8,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  recognition_frame_ctrl_if.slave  bus
);

  localparam int            CW      = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_FRAMES);
  localparam logic [3:0]    BLANK   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_SETTLE,
    S_JUDGE
  } state_t;

  state_t        state_q, state_d;
  logic          ph_q, ph_d;
  logic [19:0]   row_q, row_d;
  logic [19:0]   col_q, col_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          rrst_n_q, rrst_n_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          box_ok;

  // Box geometry: inside the active area, at least MIN_BOX on each side, and
  // top row 0 is rejected because the frame-start pulse lands there.
  function automatic logic geom_ok(input logic [19:0] r, input logic [19:0] c);
    logic [10:0] top, bot, lft, rgt;
    top = {1'b0, r[9:0]};
    bot = {1'b0, r[19:10]};
    lft = {1'b0, c[9:0]};
    rgt = {1'b0, c[19:10]};
    geom_ok = (top >= 11'd1) && (bot > top) && ((bot - top) >= 11'(MIN_BOX)) &&
              (bot < 11'(V_ACT)) && (rgt > lft) && ((rgt - lft) >= 11'(MIN_BOX)) &&
              (rgt < 11'(H_ACT));
  endfunction

  assign box_ok = geom_ok(bus.iEdge_Row, bus.iEdge_Col);

  // Next-state, box latch and verdict bookkeeping; outputs derive from next state.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    row_d   = row_q;
    col_d   = col_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    vld_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.iFrameStart) begin
          if (box_ok) begin
            row_d   = bus.iEdge_Row;
            col_d   = bus.iEdge_Col;
            ph_d    = 1'b0;
            state_d = S_CLEAR;
          end else begin
            cnt_d = '0;
          end
        end
      end
      S_CLEAR: begin
        if (bus.iFrameEnd) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (ph_q) begin
          state_d = S_SCAN;
        end else begin
          ph_d = 1'b1;
        end
      end
      S_SCAN: begin
        // Frame end wins over a coincident frame start, which is dropped.
        if (bus.iFrameEnd) begin
          ph_d    = 1'b0;
          state_d = S_SETTLE;
        end else if (bus.iFrameStart) begin
          cnt_d = '0;
          if (box_ok) begin
            row_d   = bus.iEdge_Row;
            col_d   = bus.iEdge_Col;
            ph_d    = 1'b0;
            state_d = S_CLEAR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_SETTLE: begin
        if (ph_q) state_d = S_JUDGE;
        else      ph_d    = 1'b1;
      end
      S_JUDGE: begin
        state_d = S_IDLE;
        if (bus.iDigital == BLANK) begin
          cnt_d  = '0;
          cand_d = BLANK;
        end else if (bus.iDigital == cand_q) begin
          if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) begin
              vld_d = 1'b1;
              dig_d = cand_q;
            end
          end
        end else begin
          cand_d = bus.iDigital;
          cnt_d  = CW'(1);
          if (STABLE_FRAMES == 1) begin
            vld_d = 1'b1;
            dig_d = bus.iDigital;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    en_d     = (state_d == S_SCAN);
    rrst_n_d = (state_d != S_CLEAR);
    busy_d   = (state_d != S_IDLE);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      cand_q   <= BLANK;
      dig_q    <= BLANK;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      rrst_n_q <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cand_q   <= cand_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      rrst_n_q <= rrst_n_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.oEdge_Row = row_q;
  assign bus.oEdge_Col = col_q;
  assign bus.oRecEn    = en_q;
  assign bus.oRecRst_n = rrst_n_q;
  assign bus.oDigital  = dig_q;
  assign bus.oValid    = vld_q;
  assign bus.oBusy     = busy_q;

endmodule
